// File: rtl/nfca_tx_frame.sv
// NFC-A (ISO 14443-3 type A) transmit framer: turns a byte stream into SOF, data,
// odd-parity, optional CRC_A and EOC bits, one bit per modulator tx_req slot.
module nfca_tx_frame (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_tvalid,
  output logic       tx_tready,
  input  logic [7:0] tx_tdata,
  input  logic       tx_tlast,
  input  logic [2:0] tx_tbits,
  input  logic       crc_en,
  input  logic       tx_req,
  output logic       tx_en,
  output logic       tx_bit,
  output logic       tx_busy,
  output logic       tx_underflow
);

  typedef enum logic [2:0] {IDLE, SOF, DATA, PAR, CRC, CPAR, EOC, DONE} state_t;

  // Handshake: a byte is taken when tx_tvalid && tx_tready; tx_tready is high
  // exactly while the single-entry buffer is empty.
  state_t      state;
  logic        buf_full;
  logic [7:0]  buf_data;
  logic        buf_last;
  logic [2:0]  buf_bits;
  logic        buf_crc;
  logic [7:0]  cur_byte;
  logic        cur_last;
  logic [2:0]  cur_bits;
  logic        crc_on;
  logic        crc_hi;
  logic        fetch;
  logic [2:0]  cnt;
  logic [15:0] crc;

  logic [7:0]  src_byte;
  logic        src_last;
  logic [2:0]  src_bits;
  logic        src_part;
  logic [2:0]  last_idx;
  logic        data_bit;
  logic [15:0] crc_upd;

  // The first bit of a follow-on byte comes straight from the buffer in the
  // same slot that moves it into the working register.
  always_comb begin
    src_byte = fetch ? buf_data : cur_byte;
    src_last = fetch ? buf_last : cur_last;
    src_bits = fetch ? buf_bits : cur_bits;
    src_part = src_last && (src_bits != 3'd0);
    last_idx = src_part ? 3'(src_bits - 3'd1) : 3'd7;
    data_bit = src_byte[cnt];
    crc_upd  = {1'b0, crc[15:1]} ^ ((crc[0] ^ data_bit) ? 16'h8408 : 16'h0000);
  end

  assign tx_tready = ~buf_full;
  assign tx_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      buf_full     <= 1'b0;
      buf_data     <= 8'h00;
      buf_last     <= 1'b0;
      buf_bits     <= 3'd0;
      buf_crc      <= 1'b0;
      cur_byte     <= 8'h00;
      cur_last     <= 1'b0;
      cur_bits     <= 3'd0;
      crc_on       <= 1'b0;
      crc_hi       <= 1'b0;
      fetch        <= 1'b0;
      cnt          <= 3'd0;
      crc          <= 16'h6363;
      tx_en        <= 1'b0;
      tx_bit       <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      tx_underflow <= 1'b0;
      if (tx_tvalid && tx_tready) begin
        buf_full <= 1'b1;
        buf_data <= tx_tdata;
        buf_last <= tx_tlast;
        buf_bits <= tx_tbits;
        buf_crc  <= crc_en;
      end
      if (tx_req) begin
        case (state)
          IDLE: begin
            tx_bit <= 1'b0;
            if (buf_full) begin
              tx_en    <= 1'b1;
              cur_byte <= buf_data;
              cur_last <= buf_last;
              cur_bits <= buf_bits;
              crc_on   <= buf_crc;
              buf_full <= 1'b0;
              crc      <= 16'h6363;
              crc_hi   <= 1'b0;
              fetch    <= 1'b0;
              cnt      <= 3'd0;
              state    <= SOF;
            end else begin
              tx_en <= 1'b0;
            end
          end
          SOF, DATA: begin
            if (fetch && !buf_full) begin
              tx_en        <= 1'b0;
              tx_bit       <= 1'b0;
              tx_underflow <= 1'b1;
              fetch        <= 1'b0;
              state        <= IDLE;
            end else begin
              if (fetch) begin
                cur_byte <= buf_data;
                cur_last <= buf_last;
                cur_bits <= buf_bits;
                buf_full <= 1'b0;
                fetch    <= 1'b0;
              end
              tx_en  <= 1'b1;
              tx_bit <= data_bit;
              if (!src_part) crc <= crc_upd;
              cnt <= cnt + 3'd1;
              if (cnt == last_idx) begin
                cnt   <= 3'd0;
                state <= src_part ? EOC : PAR;
              end else begin
                state <= DATA;
              end
            end
          end
          PAR: begin
            tx_en  <= 1'b1;
            tx_bit <= ~^cur_byte;
            cnt    <= 3'd0;
            if (!cur_last) begin
              fetch <= 1'b1;
              state <= DATA;
            end else if (crc_on) begin
              cur_byte <= crc[7:0];
              state    <= CRC;
            end else begin
              state <= EOC;
            end
          end
          CRC: begin
            tx_en  <= 1'b1;
            tx_bit <= cur_byte[cnt];
            cnt    <= cnt + 3'd1;
            if (cnt == 3'd7) state <= CPAR;
          end
          CPAR: begin
            tx_en  <= 1'b1;
            tx_bit <= ~^cur_byte;
            if (!crc_hi) begin
              cur_byte <= crc[15:8];
              crc_hi   <= 1'b1;
              state    <= CRC;
            end else begin
              state <= EOC;
            end
          end
          EOC: begin
            tx_en  <= 1'b1;
            tx_bit <= 1'b0;
            state  <= DONE;
          end
          DONE: begin
            tx_en  <= 1'b0;
            tx_bit <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nfca_tx_frame.sv
// Directed bench for nfca_tx_frame: hand-computed bit slots for REQA, a full byte,
// HLTA with CRC_A, underflow abort, reset mid-frame and a gapped multi-byte frame.
module tb_nfca_tx_frame;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_tvalid = 1'b0;
  logic       tx_tready;
  logic [7:0] tx_tdata = 8'h00;
  logic       tx_tlast = 1'b0;
  logic [2:0] tx_tbits = 3'd0;
  logic       crc_en = 1'b0;
  logic       tx_req = 1'b0;
  logic       tx_en;
  logic       tx_bit;
  logic       tx_busy;
  logic       tx_underflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];

  nfca_tx_frame dut (
    .clk(clk), .rstn(rstn),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tlast(tx_tlast), .tx_tbits(tx_tbits), .crc_en(crc_en),
    .tx_req(tx_req), .tx_en(tx_en), .tx_bit(tx_bit),
    .tx_busy(tx_busy), .tx_underflow(tx_underflow)
  );

  always #6 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic last, input logic [2:0] bits, input logic ce);
    int waited = 0;
    @(posedge clk); #1;
    while (!tx_tready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!tx_tready) check("push_ready", {7'd0, tx_tready}, 8'd1);
    tx_tvalid = 1'b1; tx_tdata = d; tx_tlast = last; tx_tbits = bits; crc_en = ce;
    @(posedge clk); #1;
    tx_tvalid = 1'b0;
  endtask

  // One modulator slot: a single-cycle tx_req, then sample just after the edge that saw it.
  task automatic slot();
    @(posedge clk); #1;
    tx_req = 1'b1;
    @(posedge clk); #1;
    tx_req = 1'b0;
  endtask

  task automatic exp_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, b[i]});
  endtask

  task automatic run_exp(input string tag, input int n);
    logic [1:0] e;
    for (int i = 0; i < n; i++) begin
      slot();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
      check(tag, {6'd0, tx_en, tx_bit}, {6'd0, e});
      check({tag, "_uf"}, {7'd0, tx_underflow}, 8'd0);
    end
  endtask

  task automatic run_reqa(input string tag);
    push(8'h26, 1'b1, 3'd7, 1'b0);
    exp_q.push_back(2'b10);
    exp_bits(8'h26, 7);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    run_exp(tag, 10);
    check({tag, "_busy"}, {7'd0, tx_busy}, 8'd0);
  endtask

  initial begin
    int g1, g2;
    // reset values while held in reset
    #20;
    check("rst_en", {7'd0, tx_en}, 8'd0);
    check("rst_bit", {7'd0, tx_bit}, 8'd0);
    check("rst_busy", {7'd0, tx_busy}, 8'd0);
    check("rst_uf", {7'd0, tx_underflow}, 8'd0);
    check("rst_ready", {7'd0, tx_tready}, 8'd1);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_rst_en", {7'd0, tx_en}, 8'd0);

    // idle slot with empty buffer keeps tx_en low
    exp_q.push_back(2'b00);
    run_exp("idle", 1);

    // REQA short frame
    run_reqa("reqa");

    // single full byte 0x93 with parity 1
    push(8'h93, 1'b1, 3'd0, 1'b0);
    exp_q.push_back(2'b10);
    exp_bits(8'h93, 8);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    run_exp("b93", 1);
    check("b93_busy", {7'd0, tx_busy}, 8'd1);
    run_exp("b93", 11);

    // HLTA: 50 00 + CRC_A 57 CD, 38 slots
    push(8'h50, 1'b0, 3'd0, 1'b1);
    exp_q.push_back(2'b10);
    exp_bits(8'h50, 8); exp_q.push_back(2'b11);
    exp_bits(8'h00, 8); exp_q.push_back(2'b11);
    exp_bits(8'h57, 8); exp_q.push_back(2'b10);
    exp_bits(8'hCD, 8); exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    run_exp("hlta", 1);
    push(8'h00, 1'b1, 3'd0, 1'b1);
    run_exp("hlta", 38);

    // underflow: second byte never arrives
    push(8'h11, 1'b0, 3'd0, 1'b0);
    exp_q.push_back(2'b10);
    exp_bits(8'h11, 8);
    exp_q.push_back(2'b11);
    run_exp("uflow", 10);
    slot();
    check("uflow_en", {7'd0, tx_en}, 8'd0);
    check("uflow_pulse", {7'd0, tx_underflow}, 8'd1);
    check("uflow_busy", {7'd0, tx_busy}, 8'd0);
    @(posedge clk); #1;
    check("uflow_pulse_end", {7'd0, tx_underflow}, 8'd0);
    run_reqa("after_uflow");

    // reset in the middle of DATA
    push(8'h93, 1'b1, 3'd0, 1'b0);
    exp_q.push_back(2'b10);
    exp_bits(8'h93, 3);
    run_exp("mid", 4);
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    check("mrst_en", {7'd0, tx_en}, 8'd0);
    check("mrst_bit", {7'd0, tx_bit}, 8'd0);
    check("mrst_busy", {7'd0, tx_busy}, 8'd0);
    check("mrst_ready", {7'd0, tx_tready}, 8'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    exp_q.delete();
    exp_q.push_back(2'b00);
    run_exp("mrst_trail", 1);
    run_reqa("after_rst");

    // gapped stream A5 3C 0F/4 without CRC, 24 slots then off
    g1 = $urandom_range(1, 8);
    g2 = $urandom_range(11, 17);
    push(8'hA5, 1'b0, 3'd0, 1'b0);
    exp_q.push_back(2'b10);
    exp_bits(8'hA5, 8); exp_q.push_back(2'b11);
    exp_bits(8'h3C, 8); exp_q.push_back(2'b11);
    exp_bits(8'h0F, 4);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    run_exp("gap", g1);
    push(8'h3C, 1'b0, 3'd0, 1'b0);
    run_exp("gap", g2 - g1);
    push(8'h0F, 1'b1, 3'd4, 1'b0);
    run_exp("gap", 25 - g2);
    check("gap_busy", {7'd0, tx_busy}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nfca_tx_frame.md
NFCA_TX_FRAME -- requirements
Module: nfca_tx_frame

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk (81.36 MHz, shared with the bit modulator) and rstn (0 = reset, 1 = work).
REQ-002 Port: clk  in  1  system clock.
REQ-003 Port: rstn  in  1  async active-low reset.
REQ-004 Port: tx_tvalid  in  1  byte stream valid.
REQ-005 Port: tx_tready  out  1  byte stream ready.
REQ-006 Port: tx_tdata  in  8  byte to send, LSB first on air.
REQ-007 Port: tx_tlast  in  1  marks the last byte of the frame.
REQ-008 Port: tx_tbits  in  3  valid bits in the last byte; 0 = 8 bits; ignored unless tx_tlast.
REQ-009 Port: crc_en  in  1  append CRC_A; sampled with the first byte of the frame.
REQ-010 Port: tx_req  in  1  one-cycle bit-slot request pulse from the modulator.
REQ-011 Port: tx_en  out  1  bit valid; 0 ends or withholds a frame.
REQ-012 Port: tx_bit  out  1  bit value.
REQ-013 Port: tx_busy  out  1  frame in progress.
REQ-014 Port: tx_underflow  out  1  one-cycle pulse when a frame is aborted for lack of data.

Function
REQ-015 SHALL hold one byte buffer (data, last, bits); tx_tready = buffer empty; a byte is accepted when tx_tvalid && tx_tready.
REQ-016 SHALL update tx_en/tx_bit only in the cycle after a tx_req pulse and hold them until the next tx_req (the modulator samples two cycles after tx_req).
REQ-017 States: IDLE, SOF, DATA, PAR, CRC, CPAR, EOC, DONE.
REQ-018 IDLE on tx_req: if the buffer is full, go to SOF and output tx_en=1, tx_bit=0; otherwise output tx_en=0.
REQ-019 SOF -> DATA: bits are emitted LSB first, one per tx_req.
REQ-020 A full byte (not last, or last with tx_tbits=0) SHALL be followed by PAR: odd parity, so that ones(byte)+parity is odd.
REQ-021 A last byte with tx_tbits=N≠0 SHALL send N bits, with no parity and no CRC, then go to EOC.
REQ-022 After PAR: if the byte was not last, the next byte is consumed from the buffer; if the buffer is empty at that tx_req, the frame is aborted (tx_en=0, tx_underflow pulse, go to IDLE).
REQ-023 After the last full byte's PAR: if crc_en, go to CRC; otherwise go to EOC.
REQ-024 CRC_A SHALL be computed over all full data bytes, LSB first: init 0x6363, reflected poly 0x8408, no final XOR.
REQ-025 CRC_A SHALL be sent low byte then high byte, each followed by a CPAR odd-parity bit.
REQ-026 EOC SHALL output tx_en=1, tx_bit=0.
REQ-027 DONE: at the next tx_req, output tx_en=0 and go to IDLE.
REQ-028 tx_busy SHALL be 1 in every state except IDLE.
REQ-029 The buffer SHALL remain refillable during DATA, so that back-to-back bytes stream without gaps.
REQ-030 A tx_req in the same cycle as a buffer write SHALL see the buffer as empty; the new byte is usable from the next tx_req.
REQ-031 Bytes that arrive after an abort SHALL start a new frame with SOF.

Reset
REQ-032 On rstn=0: tx_en=0, tx_bit=0, tx_busy=0, tx_underflow=0, tx_tready=1, buffer empty, state IDLE, CRC register=0x6363.
REQ-033 Reset mid-frame SHALL abort immediately, with no trailing bits on the next tx_req.
REQ-034 Outputs SHALL be stable from reset release until the first tx_req.

Verification
REQ-035 REQA: byte 0x26, tlast=1, tbits=7, crc_en=0 -> tx_bit over 9 slots = 0,0,1,1,0,0,1,0,0 with tx_en=1, then tx_en=0.
REQ-036 Byte 0x93, tlast, tbits=0, crc_en=0 -> slots 0 | 1,1,0,0,1,0,0,1 | parity 1 | EOC 0 (11 slots), then tx_en=0.
REQ-037 HLTA: bytes 0x50, 0x00, crc_en=1 -> on-air bytes 50 00 57 CD, each followed by odd parity; SOF first and EOC last; 38 slots total.
REQ-038 Two-byte frame with the second byte withheld past the first byte's PAR -> tx_en=0 at the next slot, one tx_underflow pulse, tx_busy=0.
REQ-039 Assert rstn=0 in the middle of DATA -> all outputs reach their reset values asynchronously; a subsequent 0x26/7-bit frame matches REQ-035 exactly.
REQ-040 Random tx_tvalid gaps, with bytes arriving no later than the slot before they are needed -> no underflow, and the bit stream matches a reference model.
